// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and types for the writeback stage
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wbReq_t;

  // Which source owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_MD
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO holding buffered mul/div writeback requests
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   push, pushData     write one entry (ignored when full)
//   pop, popData       drop the head entry (ignored when empty); popData is the head
//   count, full, empty occupancy status
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = $bits(wbReq_t),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter owning the register-file write port
//
// Ports:
//   clk, rst                        rising-edge clock, asynchronous active-low reset
//   mw_valid/regWrite/rd/data       MEM/WB result (never stalls, highest priority)
//   md_valid/ready/rd/data          mul/div result handshake into the buffer
//   md_issue, md_issue_rd           decode issued a mul/div to rd
//   rs1_sel, rs2_sel, stall         decode sources and RAW stall on pending mul/div
//   writeRegSel/writeData/writeEn   registered register-file write port
//   err                             sticky protocol error
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int MD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mw_valid,
  input  logic              mw_regWrite,
  input  logic [REG_AW-1:0] mw_rd,
  input  logic [XLEN-1:0]   mw_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [XLEN-1:0]   md_data,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_issue_rd,
  input  logic [REG_AW-1:0] rs1_sel,
  input  logic [REG_AW-1:0] rs2_sel,
  output logic              stall,
  output logic [REG_AW-1:0] writeRegSel,
  output logic [XLEN-1:0]   writeData,
  output logic              writeEn,
  output logic              err
);

  localparam int CW = $clog2(MD_DEPTH) + 1;
  localparam int FW = REG_AW + XLEN;

  logic              mreq;
  logic              mdPush;
  logic              mdPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CW-1:0]     fifoCount;
  logic [FW-1:0]     headWord;
  logic [REG_AW-1:0] headRd;
  logic [XLEN-1:0]   headData;
  wb_src_e           winSrc;
  logic              mdWrite;
  logic [31:0]       busy;
  logic [31:0]       busyNext;
  logic              errHit;

  assign mreq = mw_valid & mw_regWrite & (mw_rd != '0);

  // No bypass: a full buffer refuses even when it pops this cycle.
  assign md_ready = (fifoCount < CW'(MD_DEPTH));

  // Results for x0 complete the handshake but are never stored.
  assign mdPush = md_valid & md_ready & (md_rd != '0);

  wb_fifo #(
    .DEPTH (MD_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (mdPush),
    .pushData ({md_rd, md_data}),
    .pop      (mdPop),
    .popData  (headWord),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign headRd   = headWord[FW-1:XLEN];
  assign headData = headWord[XLEN-1:0];

  always_comb begin
    winSrc = WB_NONE;
    if (mreq)            winSrc = WB_PIPE;
    else if (!fifoEmpty) winSrc = WB_MD;
  end

  assign mdPop = (winSrc == WB_MD);

  // mdWrite marks that the write currently on the port came from the buffer,
  // so its busy bit can retire at the edge where the regFile captures it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeEn     <= 1'b0;
      writeRegSel <= '0;
      writeData   <= '0;
      mdWrite     <= 1'b0;
    end else begin
      writeEn <= (winSrc != WB_NONE);
      mdWrite <= (winSrc == WB_MD);
      unique case (winSrc)
        WB_PIPE: begin
          writeRegSel <= mw_rd;
          writeData   <= mw_data;
        end
        WB_MD: begin
          writeRegSel <= headRd;
          writeData   <= headData;
        end
        default: begin
          writeRegSel <= writeRegSel;
          writeData   <= writeData;
        end
      endcase
    end
  end

  // Clear first, then set, so a same-cycle reissue of the retiring rd stays busy.
  always_comb begin
    busyNext = busy;
    if (mdWrite) busyNext[writeRegSel] = 1'b0;
    if (md_issue) busyNext[md_issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_comb begin
    errHit = 1'b0;
    if (md_issue && (md_issue_rd != '0) && busy[md_issue_rd]) errHit = 1'b1;
    if (mreq && busy[mw_rd])                                  errHit = 1'b1;
    if (md_valid && (md_rd != '0) && !busy[md_rd])            errHit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busyNext;
      err  <= err | errHit;
    end
  end

  assign stall = ((rs1_sel != '0) & busy[rs1_sel]) | ((rs2_sel != '0) & busy[rs2_sel]);

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int MD_DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mw_valid, mw_regWrite;
  logic [4:0]      mw_rd;
  logic [XLEN-1:0] mw_data;
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;
  logic            md_issue;
  logic [4:0]      md_issue_rd;
  logic [4:0]      rs1_sel, rs2_sel;
  logic            stall;
  logic [4:0]      writeRegSel;
  logic [XLEN-1:0] writeData;
  logic            writeEn;
  logic            err;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .MD_DEPTH(MD_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mw_valid    (mw_valid),
    .mw_regWrite (mw_regWrite),
    .mw_rd       (mw_rd),
    .mw_data     (mw_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .rs1_sel     (rs1_sel),
    .rs2_sel     (rs2_sel),
    .stall       (stall),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .err         (err)
  );

  typedef struct {
    int          rd;
    logic [31:0] data;
  } res_t;

  // Reference model: queue of buffered results, per-register busy flags,
  // the register whose buffered write is currently on the port, expected outputs.
  res_t        mq[$];
  bit          mBusy[32];
  int          mRetire;
  bit          mEn;
  int          mSel;
  logic [31:0] mData;
  bit          mErr;
  int          inflight[$];

  int nAssert = 0;
  int nFail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit mStall();
    return (rs1_sel != 0 && mBusy[rs1_sel]) || (rs2_sel != 0 && mBusy[rs2_sel]);
  endfunction

  task automatic modelReset();
    mq.delete();
    inflight.delete();
    for (int i = 0; i < 32; i++) mBusy[i] = 0;
    mRetire = 0;
    mEn     = 0;
    mSel    = 0;
    mData   = '0;
    mErr    = 0;
  endtask

  task automatic modelEdge();
    bit   mreq;
    bit   ready;
    res_t h;
    mreq  = mw_valid && mw_regWrite && (mw_rd != 0);
    ready = (mq.size() < MD_DEPTH);
    if (md_issue && md_issue_rd != 0 && mBusy[md_issue_rd]) mErr = 1;
    if (mreq && mBusy[mw_rd]) mErr = 1;
    if (md_valid && md_rd != 0 && !mBusy[md_rd]) mErr = 1;
    if (mRetire != 0) mBusy[mRetire] = 0;
    if (md_issue && md_issue_rd != 0) mBusy[md_issue_rd] = 1;
    mRetire = 0;
    if (mreq) begin
      mEn   = 1;
      mSel  = int'(mw_rd);
      mData = mw_data;
    end else if (mq.size() > 0) begin
      h       = mq.pop_front();
      mEn     = 1;
      mSel    = h.rd;
      mData   = h.data;
      mRetire = h.rd;
    end else begin
      mEn = 0;
    end
    if (md_valid && ready && md_rd != 0) begin
      h.rd   = int'(md_rd);
      h.data = md_data;
      mq.push_back(h);
    end
  endtask

  task automatic idle();
    mw_valid    = 0;
    mw_regWrite = 0;
    mw_rd       = '0;
    mw_data     = '0;
    md_valid    = 0;
    md_rd       = '0;
    md_data     = '0;
    md_issue    = 0;
    md_issue_rd = '0;
  endtask

  task automatic pipeReq(input int rd, input logic [31:0] d);
    mw_valid    = 1;
    mw_regWrite = 1;
    mw_rd       = 5'(rd);
    mw_data     = d;
  endtask

  task automatic issue(input int rd);
    md_issue    = 1;
    md_issue_rd = 5'(rd);
  endtask

  task automatic offer(input int rd, input logic [31:0] d);
    md_valid = 1;
    md_rd    = 5'(rd);
    md_data  = d;
  endtask

  // Called at posedge+1 with inputs applied; checks combinational outputs,
  // advances the model across the edge, then checks registered outputs.
  task automatic tick();
    #1;
    chk("md_ready", 32'(md_ready), 32'(mq.size() < MD_DEPTH));
    chk("stall", 32'(stall), 32'(mStall()));
    modelEdge();
    @(posedge clk);
    #1;
    chk("writeEn", 32'(writeEn), 32'(mEn));
    chk("writeRegSel", 32'(writeRegSel), 32'(mSel));
    chk("writeData", writeData, mData);
    chk("err", 32'(err), 32'(mErr));
  endtask

  task automatic doReset();
    idle();
    rst = 0;
    #1;
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    idle();
    rs1_sel = '0;
    rs2_sel = '0;
    modelReset();

    // Reset state.
    #2;
    chk("reset_writeEn", 32'(writeEn), 32'd0);
    chk("reset_writeRegSel", 32'(writeRegSel), 32'd0);
    chk("reset_writeData", writeData, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_md_ready", 32'(md_ready), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    // Pipe-only writes.
    pipeReq(5, 32'hDEADBEEF);
    tick();
    chk("pipe_en", 32'(writeEn), 32'd1);
    chk("pipe_sel", 32'(writeRegSel), 32'd5);
    chk("pipe_data", writeData, 32'hDEADBEEF);
    idle();
    pipeReq(0, 32'h11111111);
    tick();
    chk("pipe_rd0_en", 32'(writeEn), 32'd0);
    chk("pipe_rd0_hold", writeData, 32'hDEADBEEF);
    idle();

    // Mul/div path: issue, RAW stall, N+2 write, stall drops in N+3.
    issue(7);
    tick();
    idle();
    rs1_sel = 5'd7;
    #1 chk("md_stall_rs7", 32'(stall), 32'd1);
    rs1_sel = 5'd0;
    #1 chk("md_stall_rs0", 32'(stall), 32'd0);
    rs1_sel = 5'd8;
    #1 chk("md_stall_rs8", 32'(stall), 32'd0);
    rs1_sel = 5'd7;
    offer(7, 32'h12345678);
    tick();
    idle();
    chk("md_n1_en", 32'(writeEn), 32'd0);
    tick();
    chk("md_n2_en", 32'(writeEn), 32'd1);
    chk("md_n2_sel", 32'(writeRegSel), 32'd7);
    chk("md_n2_data", writeData, 32'h12345678);
    chk("md_n2_stall", 32'(stall), 32'd1);
    tick();
    chk("md_n3_stall", 32'(stall), 32'd0);
    rs1_sel = '0;

    // Contention: four pipe writes win, then the buffer drains in FIFO order.
    issue(12);
    tick();
    issue(13);
    tick();
    idle();
    pipeReq(20, 32'hA0000020);
    offer(12, 32'hC0000012);
    tick();
    chk("cont_sel0", 32'(writeRegSel), 32'd20);
    idle();
    pipeReq(21, 32'hA0000021);
    offer(13, 32'hC0000013);
    tick();
    chk("cont_sel1", 32'(writeRegSel), 32'd21);
    idle();
    pipeReq(22, 32'hA0000022);
    #1 chk("cont_full_ready", 32'(md_ready), 32'd0);
    tick();
    chk("cont_sel2", 32'(writeRegSel), 32'd22);
    pipeReq(23, 32'hA0000023);
    tick();
    chk("cont_sel3", 32'(writeRegSel), 32'd23);
    idle();
    tick();
    chk("cont_drain0_sel", 32'(writeRegSel), 32'd12);
    chk("cont_drain0_data", writeData, 32'hC0000012);
    tick();
    chk("cont_drain1_sel", 32'(writeRegSel), 32'd13);
    chk("cont_drain1_data", writeData, 32'hC0000013);
    tick();
    chk("cont_idle_en", 32'(writeEn), 32'd0);

    // Same-cycle retire and reissue of rd 9.
    issue(9);
    tick();
    idle();
    offer(9, 32'h99990009);
    tick();
    idle();
    tick();
    chk("rd9_retire_en", 32'(writeEn), 32'd1);
    issue(9);
    tick();
    idle();
    rs1_sel = 5'd9;
    #1 chk("rd9_still_busy", 32'(stall), 32'd1);
    chk("rd9_waw_err", 32'(err), 32'd1);
    rs1_sel = '0;
    doReset();

    // Protocol errors: double issue, then pipe write to a busy rd.
    issue(3);
    tick();
    issue(3);
    tick();
    idle();
    chk("err_double_issue", 32'(err), 32'd1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    doReset();
    issue(3);
    tick();
    idle();
    pipeReq(3, 32'h33333333);
    tick();
    idle();
    chk("err_mreq_busy", 32'(err), 32'd1);
    doReset();

    // Reset mid-burst with two results buffered.
    issue(10);
    tick();
    issue(11);
    tick();
    idle();
    pipeReq(1, 32'h00000001);
    offer(10, 32'hB0000010);
    tick();
    idle();
    pipeReq(2, 32'h00000002);
    offer(11, 32'hB0000011);
    tick();
    idle();
    pipeReq(4, 32'h00000004);
    chk("burst_full", 32'(md_ready), 32'd0);
    #2 rst = 0;
    #1 chk("burst_async_en", 32'(writeEn), 32'd0);
    idle();
    modelReset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rs1_sel = 5'd10;
    rs2_sel = 5'd11;
    #1 chk("burst_ready", 32'(md_ready), 32'd1);
    chk("burst_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_no_stale", 32'(writeEn), 32'd0);
    end

    // Randomized protocol-respecting traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle();
      if (inflight.size() > 0 && $urandom_range(1) == 1) begin
        offer(inflight[0], $urandom);
      end else if ($urandom_range(15) == 0) begin
        offer(0, $urandom);
      end
      if (md_valid && md_rd != 0 && mq.size() < MD_DEPTH) void'(inflight.pop_front());
      if ($urandom_range(3) == 0 && inflight.size() < 6) begin
        r = $urandom_range(31, 1);
        if (!mBusy[r]) begin
          issue(r);
          inflight.push_back(r);
        end
      end
      if ($urandom_range(2) != 0) begin
        r = $urandom_range(31, 0);
        if (mBusy[r]) r = 0;
        mw_valid    = 1;
        mw_regWrite = 1'($urandom_range(1));
        mw_rd       = 5'(r);
        mw_data     = $urandom;
      end
      rs1_sel = 5'($urandom_range(31));
      rs2_sel = 5'($urandom_range(31));
      tick();
    end
    chk("random_err_clean", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that owns the single write port of the 32x32 RISC-V register file.
- Merges two result sources:
  - the in-order MEM/WB pipeline result (ALU/load), which can never stall;
  - results from the multi-cycle mul/div unit, which are buffered and handshaked.
- Keeps a pending-write scoreboard for mul/div destinations and gives decode a combinational RAW stall.

Parameters:
- XLEN, 32, data width.
- MD_DEPTH, 2, mul/div result buffer depth (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mw_valid  in  1  MEM/WB result valid this cycle
- mw_regWrite  in  1  MEM/WB instruction writes rd
- mw_rd  in  5  MEM/WB destination
- mw_data  in  XLEN  MEM/WB result
- md_valid  in  1  mul/div result offered
- md_ready  out  1  buffer can accept a mul/div result
- md_rd  in  5  mul/div destination
- md_data  in  XLEN  mul/div result
- md_issue  in  1  decode issued a mul/div this cycle
- md_issue_rd  in  5  destination of the issued mul/div
- rs1_sel  in  5  decode source 1
- rs2_sel  in  5  decode source 2
- stall  out  1  decode must hold (RAW on a pending mul/div)
- writeRegSel  out  5  to regFile
- writeData  out  XLEN  to regFile
- writeEn  out  1  to regFile
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst low, async): writeEn=0, writeRegSel=0, writeData=0, err=0; buffer emptied; all busy bits cleared. Any in-flight mul/div is discarded, and the upstream unit is reset by the same signal.
- Main request: mreq = mw_valid & mw_regWrite & (mw_rd!=0). A write with rd=0 is dropped and does not occupy the port.
- Buffer:
  - Push when md_valid & md_ready.
  - md_ready = (count < MD_DEPTH), combinational from count.
  - No bypass: an accepted result always enters the buffer. When full, md_ready=0, even if the buffer is popping that cycle.
  - Results with md_rd=0 are accepted and discarded (never pushed).
- Arbitration each cycle:
  - mreq has absolute priority.
  - Otherwise, if the buffer is non-empty, pop the head.
  - The winner is registered into writeRegSel/writeData with writeEn=1. With no winner, writeEn=0 and sel/data hold their last values.
- Latency:
  - MEM/WB input in cycle N -> writeEn=1 in N+1.
  - Mul/div accepted in cycle N -> writeEn=1 in N+2 at the earliest; later while mreq keeps winning.
- Starvation: the buffer waits indefinitely under continuous mreq. This is acceptable because the pipeline inserts bubbles whenever decode stalls on busy.
- Simultaneous push and pop in the same cycle: both happen; count is unchanged.
- Scoreboard busy[31:0], bit0 hardwired 0:
  - md_issue with md_issue_rd!=0 sets busy[rd] at the next edge.
  - busy[rd] clears at the rising edge at which the regFile captures that mul/div result, i.e. the end of the cycle in which writeEn=1 from the buffer source. A register is therefore never unbusy before the regFile holds the new value.
  - Set and clear of the same rd in the same cycle: set wins.
- stall (combinational) = (rs1_sel!=0 & busy[rs1_sel]) | (rs2_sel!=0 & busy[rs2_sel]).
- err (sticky until reset) is set by any of:
  - md_issue to a rd already busy (decode must stall WAW);
  - mreq to a busy rd;
  - md_valid with busy[md_rd]=0 and md_rd!=0.
- The err condition does not alter datapath behaviour.

Decomposition:
- riscv_pkg holds:
  - XLEN=32 and REG_AW=5;
  - a typedef for a writeback request {rd, data};
  - wb_src_e enum {WB_NONE, WB_PIPE, WB_MD}.
- Sub-module wb_fifo: parameterised sync FIFO (MD_DEPTH entries of wb request) with push/pop, count, full/empty, and the same clk/rst.
- Arbitration, the scoreboard and the output registers live in wb_arbiter.

Test Plan:
- Reset mid-burst: fill the buffer with 2 entries, assert rst low asynchronously -> writeEn=0 immediately, md_ready=1 and stall=0 after release, no stale write ever appears.
- Pipe-only: mw_valid=1, mw_regWrite=1, rd=5, data=0xDEADBEEF in cycle N -> writeEn=1, sel=5, data=0xDEADBEEF in N+1. Same stimulus with rd=0 -> writeEn stays 0.
- Mul/div path:
  - md_issue rd=7 -> stall=1 for rs1_sel=7 and stall=0 for rs1_sel=0 or 8;
  - md result 0x12345678 accepted in N -> write in N+2;
  - stall drops in N+3.
- Contention: mreq every cycle for 4 cycles with 2 mul/div results buffered -> md_ready=0, the pipe writes go out in order, then the buffered results drain in FIFO order in the two following cycles.
- Same-cycle issue and retire on rd=9 (busy[9] clears while a new md_issue rd=9 arrives) -> busy[9] stays 1. Note: this also flags err (WAW), so check that err=1 here.
- Protocol errors: md_issue rd=3 twice without a retire -> err=1 and stays 1 until reset. mreq to busy rd=3 -> err=1.
